// File: rtl/id_ex_pkg.sv
// id_ex_pkg: shared state encoding, ctl_ex bit positions and entry layout
// for the ID/EX pipeline register.
`default_nettype none

package id_ex_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam int EX_REG_DEST  = 3;
  localparam int EX_ALU_OP_HI = 2;
  localparam int EX_ALU_OP_LO = 1;
  localparam int EX_ALU_SRC   = 0;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 5;
  localparam int DEF_WB_W   = 2;
  localparam int DEF_M_W    = 3;

  // Entry layout at default widths; id_ex_pipe re-declares it at its own widths.
  typedef struct packed {
    logic [DEF_WB_W-1:0]   wb;
    logic [DEF_M_W-1:0]    m;
    logic [3:0]            ex;
    logic [DEF_DATA_W-1:0] npc;
    logic [DEF_DATA_W-1:0] rd1;
    logic [DEF_DATA_W-1:0] rd2;
    logic [DEF_DATA_W-1:0] sext;
    logic [DEF_REG_W-1:0]  rt;
    logic [DEF_REG_W-1:0]  rd;
  } id_ex_entry_t;

endpackage

`default_nettype wire

// File: rtl/id_ex_entry.sv
// id_ex_entry: enabled register holding one packed pipeline entry.
`default_nettype none

module id_ex_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: two-entry (main + skid) ID/EX register with valid/ready
// handshake, synchronous flush and bubble-forced control outputs.
`default_nettype none

module id_ex_pipe
  import id_ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int WB_W   = 2,
  parameter int M_W    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   ctl_wb_in,
  input  logic [M_W-1:0]    ctl_m_in,
  input  logic [3:0]        ctl_ex_in,
  input  logic [DATA_W-1:0] npc_in,
  input  logic [DATA_W-1:0] read_data_1_in,
  input  logic [DATA_W-1:0] read_data_2_in,
  input  logic [DATA_W-1:0] sign_ext_in,
  input  logic [REG_W-1:0]  rt_in,
  input  logic [REG_W-1:0]  rd_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   wb_ctl_out,
  output logic [M_W-1:0]    m_ctl_out,
  output logic              reg_dest,
  output logic              alu_src,
  output logic [1:0]        alu_op,
  output logic [DATA_W-1:0] npc_out,
  output logic [DATA_W-1:0] r_data_1_out,
  output logic [DATA_W-1:0] r_data_2_out,
  output logic [DATA_W-1:0] sign_extend_out,
  output logic [REG_W-1:0]  rt_out,
  output logic [REG_W-1:0]  rd_out,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [M_W-1:0]    m;
    logic [3:0]        ex;
    logic [DATA_W-1:0] npc;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] sext;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  state_t state, state_nxt;
  entry_t in_entry, main_d, main_q, skid_q;
  logic   main_en, main_from_skid, skid_en;
  logic   in_xfer, out_xfer;

  assign in_entry = '{wb: ctl_wb_in, m: ctl_m_in, ex: ctl_ex_in, npc: npc_in,
                      rd1: read_data_1_in, rd2: read_data_2_in, sext: sign_ext_in,
                      rt: rt_in, rd: rd_in};

  // Ready comes only from registered state, so no out_ready -> in_ready path.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          main_en   = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_en = 1'b1;
        end else if (in_xfer) begin
          skid_en   = 1'b1;
          state_nxt = TWO;
        end else if (out_xfer) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          main_en        = 1'b1;
          main_from_skid = 1'b1;
          state_nxt      = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) begin
      state_nxt = EMPTY;
      main_en   = 1'b0;
      skid_en   = 1'b0;
    end
  end

  assign main_d = main_from_skid ? skid_q : in_entry;

  id_ex_entry #(.W(ENTRY_W)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (main_en),
    .d     (main_d),
    .q     (main_q)
  );

  id_ex_entry #(.W(ENTRY_W)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (skid_en),
    .d     (in_entry),
    .q     (skid_q)
  );

  // Control fields collapse to a zero bubble whenever nothing live is held.
  assign wb_ctl_out = out_valid ? main_q.wb : '0;
  assign m_ctl_out  = out_valid ? main_q.m  : '0;
  assign reg_dest   = out_valid && main_q.ex[EX_REG_DEST];
  assign alu_src    = out_valid && main_q.ex[EX_ALU_SRC];
  assign alu_op     = out_valid ? main_q.ex[EX_ALU_OP_HI:EX_ALU_OP_LO] : 2'b00;

  assign npc_out         = main_q.npc;
  assign r_data_1_out    = main_q.rd1;
  assign r_data_2_out    = main_q.rd2;
  assign sign_extend_out = main_q.sext;
  assign rt_out          = main_q.rt;
  assign rd_out          = main_q.rd;

endmodule

`default_nettype wire

// File: doc/id_ex_pipe.md
# id_ex_pipe

Parametrised ID/EX pipeline register with valid/ready flow control. It sits between the decode stage and the execute stage of the pipelined CPU. It holds up to two decoded instructions: one output register and one skid register. Execute can therefore stall without a combinational ready path back into decode. A synchronous flush drops both entries, and control outputs are forced to a zero bubble whenever the output is invalid.

## Interface
Parameters:
- DATA_W, 32, width of npc, read data and sign-extended immediate
- REG_W, 5, width of the rt/rd register specifiers
- WB_W, 2, width of the write-back control group
- M_W, 3, width of the memory control group

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  block can accept this cycle
- ctl_wb_in  in  WB_W  write-back controls
- ctl_m_in  in  M_W  memory controls
- ctl_ex_in  in  4  execute controls; bit 3 = reg_dest, bits 2:1 = alu_op, bit 0 = alu_src
- npc_in, read_data_1_in, read_data_2_in, sign_ext_in  in  DATA_W  datapath operands
- rt_in, rd_in  in  REG_W  instruction[20:16], instruction[15:11]
- out_valid  out  1  output register holds a live instruction
- out_ready  in  1  execute consumes this cycle
- wb_ctl_out  out  WB_W
- m_ctl_out  out  M_W
- reg_dest, alu_src  out  1 each
- alu_op  out  2
- npc_out, r_data_1_out, r_data_2_out, sign_extend_out  out  DATA_W
- rt_out, rd_out  out  REG_W
- occupancy  out  2  entries held (0..2)

## Operation
Transfers:
- An input transfer occurs when in_valid && in_ready.
- An output transfer occurs when out_valid && out_ready.

State machine (state register `state`):
- EMPTY (occupancy 0)
  - in-xfer → main ← input, go to ONE.
- ONE (occupancy 1)
  - in-xfer and out-xfer → main ← input, stay in ONE.
  - in-xfer only → skid ← input, go to TWO.
  - out-xfer only → go to EMPTY.
  - neither → hold.
- TWO (occupancy 2)
  - in_ready is 0.
  - out-xfer → main ← skid, go to ONE.
  - no out-xfer → hold.

Flow control and flush:
- in_ready = (state != TWO). It is decoded from registered state only, with no combinational dependence on out_ready.
- flush has priority over everything: next state is EMPTY, and any same-cycle input transfer is discarded.
- Storage contents need not be cleared on flush; only state changes.

Bubble rule:
- While out_valid = 0, wb_ctl_out, m_ctl_out, reg_dest, alu_src and alu_op all read 0.
- Datapath outputs show the main register contents regardless of out_valid.

Ordering and integrity:
- Order is strictly FIFO.
- No entry is duplicated or lost except by flush.

Outputs:
- out_valid = (state != EMPTY).
- occupancy directly encodes state.

## Timing
- Latency: an instruction accepted at edge N appears on the outputs after edge N (out_valid high in cycle N+1) if the block was EMPTY, or if it was ONE with a same-cycle out-xfer.
- Throughput: one instruction per cycle while out_ready stays high.
- A full→not-full transition raises in_ready in the cycle after the out-xfer edge.

Reset (rst_n low, asynchronous):
- state = EMPTY, so out_valid = 0, occupancy = 0 and in_ready = 1.
- All stored fields = 0, so every output reads 0.
- Reset mid-transfer discards everything.
- Release is synchronous to clk, and the first transfer is accepted on the first edge with rst_n high.

Hold behaviour:
- Output fields are stable while out_valid && !out_ready.
- Changing inputs while in_ready = 0 has no effect.

## Structure
- Package `id_ex_pkg`:
  - state enum {EMPTY, ONE, TWO}
  - ctl_ex bit-position constants EX_REG_DEST = 3, EX_ALU_OP_HI = 2, EX_ALU_OP_LO = 1, EX_ALU_SRC = 0
  - a packed struct type for one entry (all control and datapath fields)
- One sub-module, `id_ex_entry`: a parametrised enabled register for one packed entry, instantiated twice (main, skid).

## Test plan
- **Reset:** pulse rst_n low with arbitrary inputs toggling → all outputs 0, in_ready = 1, occupancy = 0. Assert rst_n mid-stream with occupancy 2 → immediately out_valid = 0.
- **Streaming:** out_ready = 1, send npc = 0x4, 0x8, 0xC on consecutive cycles → out_valid in the following three cycles with npc_out 0x4, 0x8, 0xC and occupancy never above 1.
- **Stall/skid:** out_ready = 0, send A (npc = 0x100) then B (0x104) → occupancy 2, in_ready = 0, C held off. Raise out_ready → A, B, C delivered in order and in_ready reasserts one cycle after A leaves.
- **Flush:** occupancy 2 with flush = 1 plus simultaneous in_valid (npc = 0x200) → next cycle out_valid = 0, occupancy = 0, and 0x200 never appears.
- **Bubble:** ctl_ex_in = 4'b1111 and ctl_wb_in = 2'b11 on a flushed entry → wb_ctl_out = 0, reg_dest = alu_src = 0, alu_op = 0 while out_valid = 0.
- **Field decode:** ctl_ex_in = 4'b1010 → reg_dest = 1, alu_op = 2'b01, alu_src = 0. Also rt_in = 5'd31 and rd_in = 5'd0 pass through unchanged.
